// File: rtl/vpu_vec_exec.sv
// vpu_vec_exec -- multi-lane vector execution unit.
//   Takes one decoded instruction per in_valid/in_ready handshake and runs it
//   element-wise over a VLEN-element vector register file, LANES elements per
//   beat (NBEATS = VLEN/LANES beats), then retires it with a one-cycle done.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid / in_ready             instruction handshake
//   imm_mode, oper_type, rdst,
//   rsrc1, rsrc2, isrc              decoded instruction fields
//   done                            one-cycle retire pulse
//   zero_flag, ovf_flag, err_flag   status of the last retired instruction (held)
//   dbg_addr, dbg_elem / dbg_data   registered debug read, 1-cycle latency

// Per-lane ALU: one element, purely combinational.
module vpu_lane_alu #(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic              imm_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              ovf
);
    localparam int M = DATA_W - 1;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            5'd1: res = imm_mode ? b : a;  // MOV: immediate, or copy of rsrc1
            5'd2: begin
                res = a + b;
                ovf = (a[M] == b[M]) && (res[M] != a[M]);
            end
            5'd3: begin
                res = a - b;
                ovf = (a[M] != b[M]) && (res[M] != a[M]);
            end
            5'd4: res = a * b;
            5'd5: res = a | b;
            5'd6: res = a & b;
            5'd7: res = a ^ b;
            5'd8: res = ~(a ^ b);
            5'd9: res = ~a;
            default: res = '0;  // NOP and illegal: zero result, never written
        endcase
    end
endmodule

module vpu_vec_exec #(
    parameter int DATA_W = 16,
    parameter int VLEN   = 8,
    parameter int LANES  = 2,
    parameter int NREGS  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    imm_mode,
    input  logic [4:0]              oper_type,
    input  logic [4:0]              rdst,
    input  logic [4:0]              rsrc1,
    input  logic [4:0]              rsrc2,
    input  logic [15:0]             isrc,
    output logic                    done,
    output logic                    zero_flag,
    output logic                    ovf_flag,
    output logic                    err_flag,
    input  logic [4:0]              dbg_addr,
    input  logic [$clog2(VLEN)-1:0] dbg_elem,
    output logic [DATA_W-1:0]       dbg_data
);
    localparam int NBEATS = VLEN / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int EW     = $clog2(VLEN);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    typedef struct packed {
        logic              imm_mode;
        logic [4:0]        op;
        logic [4:0]        rdst;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DATA_W-1:0] imm;
    } instr_t;

    state_e                              state_q, state_d;
    instr_t                              ins_q;
    logic [BW-1:0]                       beat_q;
    logic                                zacc_q, oacc_q;
    logic                                zero_flag_q, ovf_flag_q, err_flag_q;
    logic [DATA_W-1:0]                   dbg_data_q;
    logic [NREGS-1:0][VLEN-1:0][DATA_W-1:0] vrf_q;

    logic [DATA_W-1:0]                   imm_ext;
    logic [LANES-1:0][EW-1:0]            lane_idx;
    logic [LANES-1:0][DATA_W-1:0]        lane_a, lane_b, lane_res;
    logic [LANES-1:0]                    lane_ovf;
    logic                                last_beat, legal, wr_en, beat_zero, beat_ovf;

    // Immediate is sign-extended (or truncated) to the element width.
    if (DATA_W > 16) begin : g_imm_sx
        assign imm_ext = {{(DATA_W-16){isrc[15]}}, isrc};
    end else begin : g_imm_tr
        assign imm_ext = isrc[DATA_W-1:0];
    end

    // Each beat touches only elements beat*LANES .. beat*LANES+LANES-1, so an
    // rdst that aliases a source never sees its own partially written result.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = EW'(int'(beat_q) * LANES + l);
        assign lane_a[l]   = vrf_q[ins_q.rs1][lane_idx[l]];
        assign lane_b[l]   = ins_q.imm_mode ? ins_q.imm : vrf_q[ins_q.rs2][lane_idx[l]];
        vpu_lane_alu #(.DATA_W(DATA_W)) u_alu (
            .op       (ins_q.op),
            .imm_mode (ins_q.imm_mode),
            .a        (lane_a[l]),
            .b        (lane_b[l]),
            .res      (lane_res[l]),
            .ovf      (lane_ovf[l])
        );
    end

    assign last_beat = (beat_q == BW'(NBEATS - 1));
    assign legal     = (ins_q.op <= 5'd9);
    assign wr_en     = (state_q == S_EXEC) && legal && (ins_q.op != 5'd0);
    assign beat_zero = (lane_res == '0);
    assign beat_ovf  = |lane_ovf;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: if (last_beat) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ins_q       <= '0;
            beat_q      <= '0;
            zacc_q      <= 1'b1;
            oacc_q      <= 1'b0;
            zero_flag_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
            err_flag_q  <= 1'b0;
            dbg_data_q  <= '0;
            vrf_q       <= '0;
        end else begin
            state_q    <= state_d;
            // Sampled before this edge's write lands: read-before-write.
            dbg_data_q <= vrf_q[dbg_addr][dbg_elem];
            case (state_q)
                S_IDLE: if (in_valid) begin
                    ins_q  <= '{imm_mode: imm_mode, op: oper_type, rdst: rdst,
                               rs1: rsrc1, rs2: rsrc2, imm: imm_ext};
                    beat_q <= '0;
                    zacc_q <= 1'b1;
                    oacc_q <= 1'b0;
                end
                S_EXEC: begin
                    beat_q <= beat_q + 1'b1;
                    zacc_q <= zacc_q & beat_zero;
                    oacc_q <= oacc_q | beat_ovf;
                    if (last_beat) begin
                        // Flags land with the transition into DONE so they are
                        // valid in the same cycle as the done pulse.
                        zero_flag_q <= legal & zacc_q & beat_zero;
                        ovf_flag_q  <= oacc_q | beat_ovf;
                        err_flag_q  <= ~legal;
                    end
                    if (wr_en) begin
                        for (int l = 0; l < LANES; l++)
                            vrf_q[ins_q.rdst][lane_idx[l]] <= lane_res[l];
                    end
                end
                default: ;
            endcase
        end
    end

    assign zero_flag = zero_flag_q;
    assign ovf_flag  = ovf_flag_q;
    assign err_flag  = err_flag_q;
    assign dbg_data  = dbg_data_q;
endmodule
